lc3_reg_viewer: RTL and testbench

//  Parametrised front-panel debug viewer for the LC-3 core: selects one of NUM_CH machine registers
//  (R0-R7, PC, MAR, MDR, IR by default) with debounced next/prev buttons and shows it in hex
//  on a multiplexed seven-segment display. The selected channel index is mirrored on the LEDs.

---
 rtl/lc3_reg_viewer.sv | 183 ++++++++++++++++++
 tb/tb_lc3_reg_viewer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_reg_viewer.sv
// lc3_reg_viewer: front-panel viewer that shows one LC-3 machine register in hex on a scanned
// seven-segment display; next/prev buttons (synchronised and debounced) pick the channel.
// Ports: clk_0, rst_n (async, active-low), btn_next/btn_prev (raw async, active-high),
//   ch_data (NUM_CH packed DATA_W words), sel_idx / led_output (selected channel index),
//   seg_output_single ({dp,g..a} active-low), seg_output_sequence (one-hot active-low digits).
// Optional feature macro: LC3_VIEW_HOLD_EN (simultaneous presses toggle a display freeze).
module lc3_reg_viewer #(
    parameter int NUM_CH       = 12,
    parameter int DATA_W       = 16,
    parameter int DIGITS       = 4,
    parameter int SCAN_CYC     = 2,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                       clk_0,
    input  logic                       rst_n,
    input  logic                       btn_next,
    input  logic                       btn_prev,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic [3:0]                 sel_idx,
    output logic [7:0]                 seg_output_single,
    output logic [DIGITS-1:0]          seg_output_sequence,
    output logic [3:0]                 led_output
);
    localparam int SW  = 4 * DIGITS;
    localparam int PW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCW = $clog2(SCAN_CYC + 1);
    localparam int DCW = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic {BLANK, SHOW} scan_e;

    // bit 0 = next button, bit 1 = prev button
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          acc_q, acc_d;
    logic [1:0]          press_q, press_d;
    logic [1:0][DCW-1:0] cnt_q, cnt_d;
    logic [3:0]          sel_q, sel_d;
    logic                hold_q, hold_d;
    scan_e               state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [SCW-1:0]      scnt_q, scnt_d;
    logic [SW-1:0]       shadow_q, shadow_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic [DATA_W-1:0]   ch_word;
    logic [3:0]          nib;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Debounce: a level must mismatch the accepted level for DEBOUNCE_CYC
    // consecutive cycles; any agreeing cycle restarts the count.
    always_comb begin
        acc_d   = acc_q;
        press_d = '0;
        for (int b = 0; b < 2; b++) begin
            cnt_d[b] = '0;
            if (sync2_q[b] != acc_q[b]) begin
                if (cnt_q[b] == DCW'(DEBOUNCE_CYC - 1)) begin
                    acc_d[b]   = sync2_q[b];
                    press_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (press_q == 2'b01) begin
            sel_d = (sel_q == 4'(NUM_CH - 1)) ? 4'd0 : sel_q + 4'd1;
        end else if (press_q == 2'b10) begin
            sel_d = (sel_q == 4'd0) ? 4'(NUM_CH - 1) : sel_q - 4'd1;
        end
    end

    always_comb begin
`ifdef LC3_VIEW_HOLD_EN
        hold_d = hold_q;
        if ((press_q == 2'b11) || ((press_q != 2'b00) && (acc_q == 2'b11))) begin
            hold_d = ~hold_q;
        end
`else
        hold_d = 1'b0;
`endif
    end

    always_comb begin
        ch_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_q == 4'(k)) ch_word = ch_data[k*DATA_W +: DATA_W];
        end
    end

    // Scan FSM; the shadow is reloaded only at frame start so a frame is coherent.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        scnt_d   = scnt_q;
        shadow_d = shadow_q;
        unique case (state_q)
            BLANK: begin
                state_d = SHOW;
                scnt_d  = '0;
                if ((ptr_q == '0) && !hold_q) shadow_d = SW'(ch_word);
            end
            SHOW: begin
                if (scnt_q == SCW'(SCAN_CYC - 1)) begin
                    state_d = BLANK;
                    ptr_d   = (ptr_q == PW'(DIGITS - 1)) ? '0 : ptr_q + 1'b1;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
        endcase
    end

    // Outputs are decoded from next-state values so the registered
    // outputs line up with the FSM state they belong to.
    always_comb begin
        nib   = '0;
        dig_d = '1;
        seg_d = 8'hFF;
        if (state_d == SHOW) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (ptr_d == PW'(i)) begin
                    nib      = shadow_d[i*4 +: 4];
                    dig_d[i] = 1'b0;
                end
            end
            seg_d = hex_seg(nib);
`ifdef LC3_VIEW_HOLD_EN
            if (hold_d && (ptr_d == '0)) seg_d[7] = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            acc_q    <= '0;
            press_q  <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            hold_q   <= 1'b0;
            state_q  <= BLANK;
            ptr_q    <= '0;
            scnt_q   <= '0;
            shadow_q <= '0;
            seg_q    <= 8'hFF;
            dig_q    <= '1;
        end else begin
            sync1_q  <= {btn_prev, btn_next};
            sync2_q  <= sync1_q;
            acc_q    <= acc_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            hold_q   <= hold_d;
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            scnt_q   <= scnt_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
        end
    end

    assign sel_idx             = sel_q;
    assign led_output          = sel_q;
    assign seg_output_single   = seg_q;
    assign seg_output_sequence = dig_q;

endmodule

// File: tb/tb_lc3_reg_viewer.sv
// tb_lc3_reg_viewer: randomized bench for lc3_reg_viewer with a frame/position-level
// reference model and a few hand-computed literal expectations.
module tb_lc3_reg_viewer;
    localparam int NUM_CH = 12;
    localparam int DEB    = 4;
    localparam int SCAN   = 2;
    localparam int DIGS   = 4;
    localparam int SLOT   = SCAN + 1;
    localparam int FRAME  = DIGS * SLOT;
    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   btn_next, btn_prev;
    logic [NUM_CH*16-1:0]   ch_data;
    logic [3:0]             sel_idx, led_output;
    logic [7:0]             seg_output_single;
    logic [DIGS-1:0]        seg_output_sequence;

    int nv = 0;
    int nf = 0;

    always #5 clk = ~clk;

    lc3_reg_viewer #(
        .NUM_CH(NUM_CH), .DATA_W(16), .DIGITS(DIGS),
        .SCAN_CYC(SCAN), .DEBOUNCE_CYC(DEB)
    ) dut (
        .clk_0(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev),
        .ch_data(ch_data), .sel_idx(sel_idx), .seg_output_single(seg_output_single),
        .seg_output_sequence(seg_output_sequence), .led_output(led_output)
    );

    typedef struct {
        int        pos;
        int        sel;
        logic [15:0] shadow;
        bit        hold;
        bit [1:0]  r1, r2, acc, pend;
        int        run [2];
    } mst_t;

    mst_t m;

    function automatic mst_t mreset();
        mst_t z;
        z.pos = 0; z.sel = 0; z.shadow = '0; z.hold = 0;
        z.r1 = 0; z.r2 = 0; z.acc = 0; z.pend = 0;
        z.run[0] = 0; z.run[1] = 0;
        return z;
    endfunction

    // One clock of the reference: frame position, shadow capture at
    // frame start, pulse application, and debounce of the two-cycle-old level.
    function automatic mst_t step(input mst_t s, input logic [1:0] raw,
                                  input logic [NUM_CH*16-1:0] chd);
        mst_t n = s;
        if (s.pos == 0 && !s.hold) n.shadow = chd[s.sel*16 +: 16];
        if (s.pend == 2'b01) n.sel = (s.sel == NUM_CH - 1) ? 0 : s.sel + 1;
        else if (s.pend == 2'b10) n.sel = (s.sel == 0) ? NUM_CH - 1 : s.sel - 1;
`ifdef LC3_VIEW_HOLD_EN
        if (s.pend == 2'b11 || (s.pend != 2'b00 && s.acc == 2'b11)) n.hold = !s.hold;
`endif
        n.pend = 2'b00;
        for (int b = 0; b < 2; b++) begin
            if (s.r2[b] != s.acc[b]) begin
                n.run[b] = s.run[b] + 1;
                if (n.run[b] == DEB) begin
                    n.acc[b]  = s.r2[b];
                    n.run[b]  = 0;
                    n.pend[b] = s.r2[b];
                end
            end else begin
                n.run[b] = 0;
            end
        end
        n.r2  = s.r1;
        n.r1  = raw;
        n.pos = (s.pos + 1) % FRAME;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mreset();
        else m <= step(m, {btn_prev, btn_next}, ch_data);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nv++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0]      es;
        logic [DIGS-1:0] eq;
        logic [DIGS-1:0] one;
        int d;
        one = 1;
        es  = 8'hFF;
        eq  = '1;
        d   = m.pos / SLOT;
        if (m.pos % SLOT != 0) begin
            es = HEX[m.shadow[d*4 +: 4]];
            if (m.hold && d == 0) es[7] = 1'b0;
            eq = ~(one << d);
        end
        chk("seg", 32'(seg_output_single), 32'(es));
        chk("seq", 32'(seg_output_sequence), 32'(eq));
        chk("sel", 32'(sel_idx), 32'(m.sel));
        chk("led", 32'(led_output), 32'(m.sel));
    end

    task automatic press(input bit nx, input bit pv, input int hi, input int lo);
        btn_next = nx;
        btn_prev = pv;
        repeat (hi) @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (m.pos == p) return;
            @(negedge clk);
        end
        chk("wait_pos_timeout", 32'(m.pos), 32'(p));
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        for (int k = 0; k < NUM_CH; k++) ch_data[k*16 +: 16] = 16'($urandom);
        ch_data[0 +: 16]   = 16'h1A2F;
        ch_data[176 +: 16] = 16'h1111;
        repeat (2) @(negedge clk);
        chk("rst_seg", 32'(seg_output_single), 32'h0FF);
        chk("rst_seq", 32'(seg_output_sequence), 32'hF);
        chk("rst_sel", 32'(sel_idx), 32'h0);
        rst_n = 1'b1;

        // frame 0 shows channel 0 = 1A2F, least significant digit first
        @(negedge clk);
        chk("d0_seg", 32'(seg_output_single), 32'h8E);
        chk("d0_seq", 32'(seg_output_sequence), 32'hE);
        repeat (2) @(negedge clk);
        chk("blank_seg", 32'(seg_output_single), 32'hFF);
        @(negedge clk);
        chk("d1_seg", 32'(seg_output_single), 32'hA4);
        chk("d1_seq", 32'(seg_output_sequence), 32'hD);
        repeat (3) @(negedge clk);
        chk("d2_seg", 32'(seg_output_single), 32'h88);
        repeat (3) @(negedge clk);
        chk("d3_seg", 32'(seg_output_single), 32'hF9);
        chk("d3_seq", 32'(seg_output_sequence), 32'h7);
        repeat (10) @(negedge clk);

        // bouncing next button, then a clean held level
        for (int i = 0; i < 4; i++) begin
            btn_next = (i % 2 == 0);
            @(negedge clk);
        end
        btn_next = 1'b1;
        repeat (6) @(negedge clk);
        chk("lat6_sel", 32'(sel_idx), 32'h0);
        @(negedge clk);
        chk("lat7_sel", 32'(sel_idx), 32'h1);
        repeat (13) @(negedge clk);
        btn_next = 1'b0;
        repeat (20) @(negedge clk);
        chk("one_inc", 32'(sel_idx), 32'h1);

        // walk to the top channel, wrap forward, wrap back
        for (int i = 0; i < 10; i++) press(1, 0, 10, 10);
        chk("sel_11", 32'(sel_idx), 32'd11);
        press(1, 0, 10, 10);
        chk("wrap_next", 32'(sel_idx), 32'd0);
        chk("wrap_led", 32'(led_output), 32'd0);
        press(0, 1, 10, 10);
        chk("wrap_prev", 32'(sel_idx), 32'd11);

        // simultaneous presses leave the selection alone (twice, so any freeze is undone)
        press(1, 1, 10, 10);
        chk("both1", 32'(sel_idx), 32'd11);
        press(1, 1, 10, 10);
        chk("both2", 32'(sel_idx), 32'd11);

        // data change mid-frame only shows from the next frame
        wait_pos(5);
        ch_data[176 +: 16] = 16'h2222;
        wait_pos(7);
        chk("mid_old", 32'(seg_output_single), 32'hF9);
        @(negedge clk);
        wait_pos(7);
        chk("mid_new", 32'(seg_output_single), 32'hA4);

        // random buttons and data
        for (int i = 0; i < 3000; i++) begin
            int k;
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 7) == 0) btn_prev = ~btn_prev;
            if ($urandom_range(0, 29) == 0) begin
                k = $urandom_range(0, NUM_CH - 1);
                ch_data[k*16 +: 16] = 16'($urandom);
            end
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (20) @(negedge clk);

        // asynchronous reset in the middle of a frame
        press(1, 0, 10, 10);
        wait_pos(5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", 32'(seg_output_single), 32'hFF);
        chk("arst_seq", 32'(seg_output_sequence), 32'hF);
        chk("arst_sel", 32'(sel_idx), 32'h0);
        chk("arst_led", 32'(led_output), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
        $finish;
    end

endmodule
